// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and bit-period math.
// Intended for reuse by a future receiver.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clocks per serial bit; the 64-bit product keeps large CLK_FRE values from overflowing.
  function automatic int calc_cycle(input int clk_fre, input int baud_rate);
    longint prod;
    prod = longint'(clk_fre) * 64'sd1000000;
    return int'(prod / longint'(baud_rate));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push is ignored when full, pop when empty.
// The head entry is presented combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in level_q.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_ext.sv
// Buffered UART transmitter: configurable data bits, parity and stop bits, with
// back-to-back frames whenever the buffer holds another word at the end of STOP.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int CLK_FRE    = 27,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [DATA_BITS-1:0]            tx_data,
  input  logic                            tx_data_valid,
  output logic                            tx_data_ready,
  output logic                            tx_pin,
  output logic                            tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);

  localparam int CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int LW    = $clog2(FIFO_DEPTH + 1);
  localparam int CW    = $clog2(STOP_BITS * CYCLE + 1);
  localparam int BW    = $clog2(DATA_BITS);

  localparam logic [CW-1:0] BIT_LAST  = CW'(CYCLE - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CYCLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || CYCLE < 2) begin : g_bad_param
    $error("uart_tx_ext: illegal parameter set (CYCLE=%0d)", CYCLE);
  end

  tx_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   tx_pin_q, tx_pin_d;
  logic                   tx_data_ready_q, tx_data_ready_d;

  logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                   push_ok, pop_ok, load;
  logic [DATA_BITS-1:0]   fifo_rdata;
  logic [LW-1:0]          fifo_level_w, level_nxt;

  assign fifo_push = tx_data_valid && tx_data_ready_q;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (tx_data),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level_w)
  );

  // Ready is registered from the post-edge occupancy so a full buffer never advertises space.
  assign push_ok = fifo_push && !fifo_full;
  assign pop_ok  = fifo_pop && !fifo_empty;

  always_comb begin
    level_nxt = fifo_level_w;
    case ({push_ok, pop_ok})
      2'b10:   level_nxt = fifo_level_w + LW'(1);
      2'b01:   level_nxt = fifo_level_w - LW'(1);
      default: level_nxt = fifo_level_w;
    endcase
    tx_data_ready_d = (level_nxt != LW'(FIFO_DEPTH));
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    tx_pin_d = tx_pin_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        tx_pin_d = 1'b1;
        if (!fifo_empty) load = 1'b1;
      end
      ST_START: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = ST_DATA;
          cnt_d    = '0;
          bit_d    = '0;
          tx_pin_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (bit_q == DATA_LAST) begin
            if (PARITY != PARITY_NONE) begin
              state_d  = ST_PARITY;
              tx_pin_d = par_q;
            end else begin
              state_d  = ST_STOP;
              tx_pin_d = 1'b1;
            end
          end else begin
            bit_d    = bit_q + BW'(1);
            shift_d  = shift_q >> 1;
            tx_pin_d = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          state_d  = ST_STOP;
          cnt_d    = '0;
          tx_pin_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        if (cnt_q == STOP_LAST) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            tx_pin_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tx_pin_d = 1'b1;
      end
    endcase
    // Shared frame launch from IDLE or straight out of STOP.
    if (load) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      par_d    = (^fifo_rdata) ^ (PARITY == PARITY_ODD);
      state_d  = ST_START;
      cnt_d    = '0;
      bit_d    = '0;
      tx_pin_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      bit_q           <= '0;
      shift_q         <= '0;
      par_q           <= 1'b0;
      tx_pin_q        <= 1'b1;
      tx_data_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_q           <= bit_d;
      shift_q         <= shift_d;
      par_q           <= par_d;
      tx_pin_q        <= tx_pin_d;
      tx_data_ready_q <= tx_data_ready_d;
    end
  end

  assign tx_pin        = tx_pin_q;
  assign tx_data_ready = tx_data_ready_q;
  assign fifo_level    = fifo_level_w;
  assign tx_busy       = (state_q != ST_IDLE) || (fifo_level_w != '0);

endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: four frame formats side by side, each checked cycle by cycle
// against a word-queue model of the serial line, occupancy, ready and busy.
module tb_uart_tx_ext;

  localparam int NDUT  = 4;
  localparam int CYC   = 4;
  localparam int DEPTH = 4;
  localparam int DB  [NDUT] = '{8, 7, 7, 9};
  localparam int PAR [NDUT] = '{0, 2, 1, 2};
  localparam int SB  [NDUT] = '{1, 1, 2, 2};

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [8:0]      tx_data  [NDUT];
  logic [NDUT-1:0] tx_valid;
  logic [NDUT-1:0] tx_ready;
  logic [NDUT-1:0] tx_pin;
  logic [NDUT-1:0] tx_busy;
  logic [2:0]      fifo_level [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_ext #(
      .CLK_FRE    (1),
      .BAUD_RATE  (250000),
      .DATA_BITS  (DB[g]),
      .PARITY     (PAR[g]),
      .STOP_BITS  (SB[g]),
      .FIFO_DEPTH (DEPTH)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .tx_data       (tx_data[g][DB[g]-1:0]),
      .tx_data_valid (tx_valid[g]),
      .tx_data_ready (tx_ready[g]),
      .tx_pin        (tx_pin[g]),
      .tx_busy       (tx_busy[g]),
      .fifo_level    (fifo_level[g])
    );
  end

  // Model: words accepted but not yet on the line, plus the frame being shifted out.
  logic [8:0] expq [NDUT][$];
  logic [8:0] srcq [NDUT][$];
  bit         in_frame [NDUT];
  int         tpos [NDUT];
  logic [8:0] cur [NDUT];
  logic [3:0] obs [NDUT];
  bit         pend [NDUT];
  logic [8:0] pend_w [NDUT];
  bit         rnd_mode;
  int         n_tests, n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] mask(input int d);
    return 9'((1 << DB[d]) - 1);
  endfunction

  function automatic int frame_len(input int d);
    return CYC * (1 + DB[d] + ((PAR[d] != 0) ? 1 : 0) + SB[d]);
  endfunction

  // Line level for bit slot p of a frame carrying word w.
  function automatic logic exp_bit(input int d, input logic [8:0] w, input int p);
    if (p == 0) return 1'b0;
    if (p <= DB[d]) return w[p-1];
    if (PAR[d] != 0 && p == DB[d] + 1)
      return (($countones(w) % 2) == 1) ^ (PAR[d] == 1);
    return 1'b1;
  endfunction

  function automatic bit all_idle();
    for (int d = 0; d < NDUT; d++)
      if (srcq[d].size() != 0 || expq[d].size() != 0 || in_frame[d] || pend[d]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++) begin
      expq[d].delete();
      srcq[d].delete();
      in_frame[d] = 1'b0;
      tpos[d]     = 0;
      obs[d]      = '0;
      pend[d]     = 1'b0;
      tx_valid[d] = 1'b0;
    end
  endtask

  task automatic step();
    bit act;
    bit v;
    logic [8:0] w;
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (!in_frame[d] && expq[d].size() > 0) begin
        cur[d]      = expq[d].pop_front();
        in_frame[d] = 1'b1;
        tpos[d]     = 0;
      end
      act = in_frame[d];
      if (act) begin
        obs[d] = {obs[d][2:0], tx_pin[d]};
        if (tpos[d] % CYC == CYC - 1)
          chk($sformatf("d%0d_w%0h_slot%0d", d, cur[d], tpos[d] / CYC), obs[d],
              {4{exp_bit(d, cur[d], tpos[d] / CYC)}});
        tpos[d]++;
        if (tpos[d] == frame_len(d)) in_frame[d] = 1'b0;
      end else begin
        chk($sformatf("d%0d_idle_pin", d), tx_pin[d], 1);
      end
      if (pend[d]) expq[d].push_back(pend_w[d]);
      chk($sformatf("d%0d_level", d), fifo_level[d], expq[d].size());
      chk($sformatf("d%0d_ready", d), tx_ready[d], expq[d].size() != DEPTH);
      chk($sformatf("d%0d_busy", d), tx_busy[d], act || expq[d].size() != 0);
      v = (srcq[d].size() != 0) && (!rnd_mode || $urandom_range(3) != 0);
      w = v ? srcq[d][0] : 9'($urandom);
      tx_valid[d] = v;
      tx_data[d]  = w;
      pend[d]     = v && tx_ready[d];
      pend_w[d]   = w & mask(d);
      if (pend[d]) void'(srcq[d].pop_front());
    end
  endtask

  task automatic load(input logic [8:0] w);
    for (int d = 0; d < NDUT; d++) srcq[d].push_back(w);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (n < budget && !all_idle()) begin
      step();
      n++;
    end
    chk("drain_within_budget", all_idle(), 1);
    repeat (3) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("d%0d_rst_pin", d), tx_pin[d], 1);
      chk($sformatf("d%0d_rst_level", d), fifo_level[d], 0);
      chk($sformatf("d%0d_rst_ready", d), tx_ready[d], 0);
      chk($sformatf("d%0d_rst_busy", d), tx_busy[d], 0);
    end
    clear_model();
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) chk($sformatf("d%0d_rst_hold_ready", d), tx_ready[d], 0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    n_tests  = 0;
    n_fail   = 0;
    rnd_mode = 1'b0;
    for (int d = 0; d < NDUT; d++) tx_data[d] = '0;
    clear_model();
    #2;
    do_reset();
    step();
    for (int d = 0; d < NDUT; d++) chk($sformatf("d%0d_ready_after_release", d), tx_ready[d], 1);

    load(9'h055); run_until_idle(200);
    load(9'h041); run_until_idle(200);
    load(9'h0FF); run_until_idle(200);
    for (int i = 1; i <= 6; i++) load(9'(i));
    run_until_idle(800);

    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++) load(9'($urandom));
    run_until_idle(20000);
    rnd_mode = 1'b0;

    // Abort mid-frame: reset while word 0xA5 is on data bit 3 with two words queued behind it.
    load(9'h0A5); load(9'h011); load(9'h022);
    n = 0;
    while (n < 200 && !(in_frame[0] && tpos[0] == 18)) begin
      step();
      n++;
    end
    chk("mid_frame_reached", in_frame[0] && tpos[0] == 18, 1);
    chk("mid_frame_level", fifo_level[0], 2);
    chk("mid_frame_pin_bit3", tx_pin[0], 0);
    #2;
    do_reset();
    step();
    for (int d = 0; d < NDUT; d++) chk($sformatf("d%0d_ready_after_abort", d), tx_ready[d], 1);
    repeat (60) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
